id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports (name direction width meaning): i_clk in 1 sole clock, rising edge; i_rst in 1 reset, synchronous, active-high.
REQ-002 SHALL have i_hold in 1: downstream freeze; i_flush in 1: EX-resolved branch/jump kills the ID instruction.
REQ-003 SHALL have i_ID_valid in 1; i_ID_Rs, i_ID_Rt, i_ID_Rd in 6 each: register specifiers; i_ID_uses_Rs, i_ID_uses_Rt in 1 each: operand actually read.
REQ-004 SHALL have i_ID_data1, i_ID_data2, i_ID_imm in 32 each; i_ID_reg_write, i_ID_mem_read, i_ID_mem_write, i_ID_alu_src in 1 each; i_ID_mem_to_reg in 2; i_ID_alu_ctrl in 5.
REQ-005 SHALL have o_stall out 1: freeze PC and IF/ID this cycle.
REQ-006 SHALL have registered outputs o_ID_EX_<field> mirroring each REQ-003/004 input field, plus o_ID_EX_valid out 1.

Function
REQ-007 Hazard SHALL be combinational: o_ID_EX_valid & o_ID_EX_mem_read & o_ID_EX_reg_write & (o_ID_EX_Rd != 0) & ((i_ID_uses_Rs & Rd==i_ID_Rs) | (i_ID_uses_Rt & Rd==i_ID_Rt)) & i_ID_valid.
REQ-008 o_stall SHALL equal i_hold | (hazard & !i_flush), combinational, same cycle.
REQ-009 Per-edge update priority SHALL be: i_rst > i_hold > i_flush > hazard > normal load.
REQ-010 i_hold=1: every registered output SHALL keep its value; i_flush and hazard ignored.
REQ-011 i_flush=1 (no hold): register SHALL load a bubble.
REQ-012 Hazard (no hold, no flush): register SHALL load a bubble; ID instruction re-presented next cycle by frozen upstream.
REQ-013 Bubble SHALL mean valid, reg_write, mem_read, mem_write = 0; mem_to_reg, alu_ctrl, alu_src = 0; Rs/Rt/Rd/data/imm = 0.
REQ-014 Normal load SHALL copy every ID field; i_ID_valid=0 SHALL load a bubble.
REQ-015 Load latency SHALL be exactly one cycle; exactly one bubble per load-use pair, since the bubble clears the hazard next cycle.
REQ-016 Register $0 as load destination SHALL never raise hazard; unused operands (uses_*=0) SHALL never raise hazard.
REQ-017 Rs and Rt both matching SHALL still produce a single one-cycle bubble.

Reset
REQ-018 i_rst=1 at a rising edge SHALL clear all registered outputs to 0 (bubble state) regardless of i_hold/i_flush.
REQ-019 During reset, o_stall SHALL follow REQ-008 from the cleared state (i.e. i_hold only).
REQ-020 Reset mid-stall SHALL discard the pending hazard; no extra bubble after release.

Configuration
REQ-021 Macro ID_EX_PERF_EN SHALL, when defined, add o_bubble_cnt out 32 (hazard bubbles) and o_flush_cnt out 32 (flush bubbles).
REQ-022 With ID_EX_PERF_EN, counters SHALL increment by 1 on each edge where REQ-011/012 loads a bubble, not when held, saturate at 0xFFFFFFFF, and clear on i_rst.
REQ-023 Without ID_EX_PERF_EN, the counter ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-024 lw Rd=8 in EX, ID add Rs=8 uses_Rs=1 -> o_stall=1 one cycle, next EX valid=0 reg_write=0, then add loads with Rs=8.
REQ-025 lw Rd=0 in EX, ID Rs=0 uses_Rs=1 -> o_stall=0, add loads next edge.
REQ-026 Hazard plus i_flush=1 same cycle -> o_stall=0, bubble loaded, o_flush_cnt +1, o_bubble_cnt unchanged.
REQ-027 i_hold=1 for 3 cycles with i_flush=1 -> outputs unchanged all 3 cycles, o_stall=1; hold drop with flush=1 -> bubble.
REQ-028 i_rst=1 during hazard stall -> all outputs 0 next edge; after release a non-hazard instruction loads with no extra bubble.
REQ-029 With ID_EX_PERF_EN, preload o_bubble_cnt=0xFFFFFFFE via 2 hazards' force -> counts to 0xFFFFFFFF and holds on further hazards.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID->EX pipeline register bus: decoded ID fields in, EX copy out.
// master = decode side, slave = id_ex_stage.
interface id_ex_stage_if;
  logic        i_hold;
  logic        i_flush;
  logic        i_ID_valid;
  logic [5:0]  i_ID_Rs;
  logic [5:0]  i_ID_Rt;
  logic [5:0]  i_ID_Rd;
  logic        i_ID_uses_Rs;
  logic        i_ID_uses_Rt;
  logic [31:0] i_ID_data1;
  logic [31:0] i_ID_data2;
  logic [31:0] i_ID_imm;
  logic        i_ID_reg_write;
  logic        i_ID_mem_read;
  logic        i_ID_mem_write;
  logic        i_ID_alu_src;
  logic [1:0]  i_ID_mem_to_reg;
  logic [4:0]  i_ID_alu_ctrl;
  logic        o_stall;
  logic        o_ID_EX_valid;
  logic [5:0]  o_ID_EX_Rs;
  logic [5:0]  o_ID_EX_Rt;
  logic [5:0]  o_ID_EX_Rd;
  logic        o_ID_EX_uses_Rs;
  logic        o_ID_EX_uses_Rt;
  logic [31:0] o_ID_EX_data1;
  logic [31:0] o_ID_EX_data2;
  logic [31:0] o_ID_EX_imm;
  logic        o_ID_EX_reg_write;
  logic        o_ID_EX_mem_read;
  logic        o_ID_EX_mem_write;
  logic        o_ID_EX_alu_src;
  logic [1:0]  o_ID_EX_mem_to_reg;
  logic [4:0]  o_ID_EX_alu_ctrl;

  modport master (
    output i_hold, i_flush, i_ID_valid,
    output i_ID_Rs, i_ID_Rt, i_ID_Rd,
    output i_ID_uses_Rs, i_ID_uses_Rt,
    output i_ID_data1, i_ID_data2, i_ID_imm,
    output i_ID_reg_write, i_ID_mem_read,
    output i_ID_mem_write, i_ID_alu_src,
    output i_ID_mem_to_reg, i_ID_alu_ctrl,
    input  o_stall, o_ID_EX_valid,
    input  o_ID_EX_Rs, o_ID_EX_Rt, o_ID_EX_Rd,
    input  o_ID_EX_uses_Rs, o_ID_EX_uses_Rt,
    input  o_ID_EX_data1, o_ID_EX_data2,
    input  o_ID_EX_imm, o_ID_EX_reg_write,
    input  o_ID_EX_mem_read, o_ID_EX_mem_write,
    input  o_ID_EX_alu_src, o_ID_EX_mem_to_reg,
    input  o_ID_EX_alu_ctrl
  );

  modport slave (
    input  i_hold, i_flush, i_ID_valid,
    input  i_ID_Rs, i_ID_Rt, i_ID_Rd,
    input  i_ID_uses_Rs, i_ID_uses_Rt,
    input  i_ID_data1, i_ID_data2, i_ID_imm,
    input  i_ID_reg_write, i_ID_mem_read,
    input  i_ID_mem_write, i_ID_alu_src,
    input  i_ID_mem_to_reg, i_ID_alu_ctrl,
    output o_stall, o_ID_EX_valid,
    output o_ID_EX_Rs, o_ID_EX_Rt, o_ID_EX_Rd,
    output o_ID_EX_uses_Rs, o_ID_EX_uses_Rt,
    output o_ID_EX_data1, o_ID_EX_data2,
    output o_ID_EX_imm, o_ID_EX_reg_write,
    output o_ID_EX_mem_read, o_ID_EX_mem_write,
    output o_ID_EX_alu_src, o_ID_EX_mem_to_reg,
    output o_ID_EX_alu_ctrl
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard bubble and flush.
// Define ID_EX_PERF_EN to add saturating bubble/flush counters.
module id_ex_stage (
  input logic i_clk,
  input logic i_rst,
  id_ex_stage_if.slave bus
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0] o_bubble_cnt,
  output logic [31:0] o_flush_cnt
`endif
);

  typedef struct packed {
    logic        valid;
    logic [5:0]  rs;
    logic [5:0]  rt;
    logic [5:0]  rd;
    logic        uses_rs;
    logic        uses_rt;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic [1:0]  mem_to_reg;
    logic [4:0]  alu_ctrl;
  } ex_t;

  ex_t  id_w;
  ex_t  ex_q;
  logic hazard;
  logic rs_hit;
  logic rt_hit;
  logic kill;

  assign id_w = {
    bus.i_ID_valid, bus.i_ID_Rs,
    bus.i_ID_Rt, bus.i_ID_Rd,
    bus.i_ID_uses_Rs, bus.i_ID_uses_Rt,
    bus.i_ID_data1, bus.i_ID_data2,
    bus.i_ID_imm, bus.i_ID_reg_write,
    bus.i_ID_mem_read, bus.i_ID_mem_write,
    bus.i_ID_alu_src, bus.i_ID_mem_to_reg,
    bus.i_ID_alu_ctrl
  };

  assign rs_hit = bus.i_ID_uses_Rs
                & (ex_q.rd == bus.i_ID_Rs);
  assign rt_hit = bus.i_ID_uses_Rt
                & (ex_q.rd == bus.i_ID_Rt);

  assign hazard = ex_q.valid & ex_q.mem_read
                & ex_q.reg_write
                & (ex_q.rd != 6'd0)
                & (rs_hit | rt_hit)
                & bus.i_ID_valid;

  assign bus.o_stall = bus.i_hold
                     | (hazard & ~bus.i_flush);

  assign kill = bus.i_flush | hazard
              | ~bus.i_ID_valid;

  // Pipeline register: hold keeps, flush/hazard/invalid load a bubble
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ex_q <= '0;
    end else if (!bus.i_hold) begin
      if (kill) ex_q <= '0;
      else      ex_q <= id_w;
    end
  end

  assign bus.o_ID_EX_valid      = ex_q.valid;
  assign bus.o_ID_EX_Rs         = ex_q.rs;
  assign bus.o_ID_EX_Rt         = ex_q.rt;
  assign bus.o_ID_EX_Rd         = ex_q.rd;
  assign bus.o_ID_EX_uses_Rs    = ex_q.uses_rs;
  assign bus.o_ID_EX_uses_Rt    = ex_q.uses_rt;
  assign bus.o_ID_EX_data1      = ex_q.data1;
  assign bus.o_ID_EX_data2      = ex_q.data2;
  assign bus.o_ID_EX_imm        = ex_q.imm;
  assign bus.o_ID_EX_reg_write  = ex_q.reg_write;
  assign bus.o_ID_EX_mem_read   = ex_q.mem_read;
  assign bus.o_ID_EX_mem_write  = ex_q.mem_write;
  assign bus.o_ID_EX_alu_src    = ex_q.alu_src;
  assign bus.o_ID_EX_mem_to_reg = ex_q.mem_to_reg;
  assign bus.o_ID_EX_alu_ctrl   = ex_q.alu_ctrl;

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_q;
  logic [31:0] flush_q;

  // Saturating counts of flush bubbles and hazard bubbles
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bubble_q <= '0;
      flush_q  <= '0;
    end else if (!bus.i_hold) begin
      if (bus.i_flush) begin
        if (flush_q != '1) flush_q <= flush_q + 32'd1;
      end else if (hazard) begin
        if (bubble_q != '1) bubble_q <= bubble_q + 32'd1;
      end
    end
  end

  assign o_bubble_cnt = bubble_q;
  assign o_flush_cnt  = flush_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table, corner
// sequences and randomized traffic against a behavioural model.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [5:0]  rs;
    logic [5:0]  rt;
    logic [5:0]  rd;
    logic        urs;
    logic        urt;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        asrc;
    logic [1:0]  m2r;
    logic [4:0]  actl;
  } fld_t;

  typedef struct {
    logic       hold;
    logic       flush;
    logic       v;
    logic [5:0] rs;
    logic [5:0] rt;
    logic [5:0] rd;
    logic       urs;
    logic       urt;
    logic       mr;
    logic       rw;
    logic       e_stall;
    logic       e_v;
    logic [5:0] e_rd;
    logic [5:0] e_rs;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  fld_t m_ex;
  logic [31:0] m_bub;
  logic [31:0] m_fl;

  id_ex_stage_if bus ();

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt;
  logic [31:0] flush_cnt;
  id_ex_stage dut (
    .i_clk(clk), .i_rst(rst), .bus(bus),
    .o_bubble_cnt(bubble_cnt),
    .o_flush_cnt(flush_cnt)
  );
`else
  id_ex_stage dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  function automatic fld_t act();
    return {
      bus.o_ID_EX_valid, bus.o_ID_EX_Rs,
      bus.o_ID_EX_Rt, bus.o_ID_EX_Rd,
      bus.o_ID_EX_uses_Rs, bus.o_ID_EX_uses_Rt,
      bus.o_ID_EX_data1, bus.o_ID_EX_data2,
      bus.o_ID_EX_imm, bus.o_ID_EX_reg_write,
      bus.o_ID_EX_mem_read, bus.o_ID_EX_mem_write,
      bus.o_ID_EX_alu_src, bus.o_ID_EX_mem_to_reg,
      bus.o_ID_EX_alu_ctrl
    };
  endfunction

  task automatic chk(string nm, logic [127:0] a,
                     logic [127:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endtask

  function automatic fld_t mk(logic v, logic [5:0] rs,
      logic [5:0] rt, logic [5:0] rd, logic urs,
      logic urt, logic mr, logic rw);
    fld_t f;
    f = '0;
    f.valid = v; f.rs = rs; f.rt = rt; f.rd = rd;
    f.urs = urs; f.urt = urt; f.mr = mr; f.rw = rw;
    f.d1 = $urandom; f.d2 = $urandom;
    f.imm = $urandom; f.mw = 1'($urandom);
    f.asrc = 1'($urandom); f.m2r = 2'($urandom);
    f.actl = 5'($urandom);
    return f;
  endfunction

  // Load-use: EX is a live load writing a nonzero reg that ID reads
  function automatic logic m_haz(fld_t ex, fld_t id);
    logic hit;
    hit = (id.urs && id.rs == ex.rd)
       || (id.urt && id.rt == ex.rd);
    return ex.valid && ex.mr && ex.rw
        && ex.rd != 0 && id.valid && hit;
  endfunction

  task automatic drive(logic h, logic f, logic r, fld_t id);
    rst                 = r;
    bus.i_hold          = h;
    bus.i_flush         = f;
    bus.i_ID_valid      = id.valid;
    bus.i_ID_Rs         = id.rs;
    bus.i_ID_Rt         = id.rt;
    bus.i_ID_Rd         = id.rd;
    bus.i_ID_uses_Rs    = id.urs;
    bus.i_ID_uses_Rt    = id.urt;
    bus.i_ID_data1      = id.d1;
    bus.i_ID_data2      = id.d2;
    bus.i_ID_imm        = id.imm;
    bus.i_ID_reg_write  = id.rw;
    bus.i_ID_mem_read   = id.mr;
    bus.i_ID_mem_write  = id.mw;
    bus.i_ID_alu_src    = id.asrc;
    bus.i_ID_mem_to_reg = id.m2r;
    bus.i_ID_alu_ctrl   = id.actl;
  endtask

  task automatic cyc(logic h, logic f, logic r, fld_t id,
                     output logic st);
    logic hz;
    @(negedge clk);
    drive(h, f, r, id);
    #1;
    hz = m_haz(m_ex, id);
    st = bus.o_stall;
    chk("stall", 128'(st), 128'(h || (hz && !f)));
    if (r) begin
      m_ex = '0; m_bub = 0; m_fl = 0;
    end else if (!h) begin
      if (f) begin
        m_ex = '0;
        if (m_fl != 32'hFFFFFFFF) m_fl++;
      end else if (hz) begin
        m_ex = '0;
        if (m_bub != 32'hFFFFFFFF) m_bub++;
      end else if (!id.valid) begin
        m_ex = '0;
      end else begin
        m_ex = id;
      end
    end
    @(posedge clk);
    #1;
    chk("regs", 128'(act()), 128'(m_ex));
`ifdef ID_EX_PERF_EN
    chk("bubble_cnt", 128'(bubble_cnt), 128'(m_bub));
    chk("flush_cnt", 128'(flush_cnt), 128'(m_fl));
`endif
  endtask

  vec_t tbl[17];
  logic st;
  fld_t id;

  initial begin
    tbl[0]  = '{0,0,1, 1, 0, 8,1,0,1,1, 0,1, 8,1};
    tbl[1]  = '{0,0,1, 8, 2, 9,1,1,0,1, 1,0, 0,0};
    tbl[2]  = '{0,0,1, 8, 2, 9,1,1,0,1, 0,1, 9,8};
    tbl[3]  = '{0,0,1, 0, 0, 0,0,0,1,1, 0,1, 0,0};
    tbl[4]  = '{0,0,1, 0, 3, 5,1,1,0,1, 0,1, 5,0};
    tbl[5]  = '{0,0,1, 1, 0, 7,1,0,1,1, 0,1, 7,1};
    tbl[6]  = '{0,0,1, 7, 7, 3,0,0,0,1, 0,1, 3,7};
    tbl[7]  = '{0,0,1, 2, 0, 6,1,0,1,1, 0,1, 6,2};
    tbl[8]  = '{0,0,1, 6, 6,10,1,1,0,1, 1,0, 0,0};
    tbl[9]  = '{0,0,1, 6, 6,10,1,1,0,1, 0,1,10,6};
    tbl[10] = '{0,0,1, 1, 0, 4,1,0,1,1, 0,1, 4,1};
    tbl[11] = '{0,1,1, 4, 0,11,1,0,0,1, 0,0, 0,0};
    tbl[12] = '{0,0,0, 4, 0,12,1,0,1,1, 0,0, 0,0};
    tbl[13] = '{0,0,1, 1, 0,13,1,0,1,1, 0,1,13,1};
    tbl[14] = '{1,1,1,13, 0,14,1,0,0,1, 1,1,13,1};
    tbl[15] = '{0,0,1, 0,13,14,0,1,0,1, 1,0, 0,0};
    tbl[16] = '{0,0,1, 0,13,14,0,1,0,1, 0,1,14,0};

    drive(1'b1, 1'b1, 1'b1, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_regs", 128'(act()), 128'(0));
    m_ex = '0; m_bub = 0; m_fl = 0;

    for (int i = 0; i < 17; i++) begin
      id = mk(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].rd,
              tbl[i].urs, tbl[i].urt, tbl[i].mr, tbl[i].rw);
      cyc(tbl[i].hold, tbl[i].flush, 1'b0, id, st);
      chk($sformatf("tbl%0d_stall", i), 128'(st),
          128'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_out", i),
          128'({bus.o_ID_EX_valid, bus.o_ID_EX_Rd,
                bus.o_ID_EX_Rs}),
          128'({tbl[i].e_v, tbl[i].e_rd, tbl[i].e_rs}));
    end

    // Hold with flush for three cycles, then flush alone
    cyc(1'b0, 1'b0, 1'b0, mk(1,1,0,8,1,0,1,1), st);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b1, 1'b0, mk(1,8,0,9,1,0,0,1), st);
      chk("hold_keep",
          128'({bus.o_ID_EX_valid, bus.o_ID_EX_Rd}),
          128'({1'b1, 6'd8}));
    end
    cyc(1'b0, 1'b1, 1'b0, mk(1,2,0,9,1,0,0,1), st);
    chk("hold_drop_flush", 128'(bus.o_ID_EX_valid), 128'(0));

    // Reset in the middle of a load-use stall
    cyc(1'b0, 1'b0, 1'b0, mk(1,1,0,8,1,0,1,1), st);
    id = mk(1,8,0,9,1,0,0,1);
    cyc(1'b0, 1'b0, 1'b1, id, st);
    chk("rst_stall_pre", 128'(st), 128'(1));
    chk("rst_clear", 128'(act()), 128'(0));
    cyc(1'b0, 1'b0, 1'b1, id, st);
    chk("rst_stall_after", 128'(st), 128'(0));
    cyc(1'b0, 1'b0, 1'b0, id, st);
    chk("rst_no_bubble",
        128'({st, bus.o_ID_EX_valid, bus.o_ID_EX_Rd,
              bus.o_ID_EX_Rs}),
        128'({1'b0, 1'b1, 6'd9, 6'd8}));

`ifdef ID_EX_PERF_EN
    // Saturation: preload to one below max, then two hazards
    @(negedge clk);
    force dut.bubble_q = 32'hFFFFFFFE;
    #1;
    release dut.bubble_q;
    m_bub = 32'hFFFFFFFE;
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 1'b0, 1'b0, mk(1,1,0,5,1,0,1,1), st);
      cyc(1'b0, 1'b0, 1'b0, mk(1,5,0,6,1,0,0,1), st);
      chk("bub_sat", 128'(bubble_cnt),
          128'(32'hFFFFFFFF));
    end
`endif

    for (int n = 0; n < 3000; n++) begin
      id = mk(($urandom % 8) != 0,
              6'($urandom_range(0, 3)),
              6'($urandom_range(0, 3)),
              6'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom));
      cyc(($urandom % 8) == 0, ($urandom % 8) == 0,
          ($urandom % 64) == 0, id, st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
